// File: rtl/game_pkg.sv
// Shared game types: player-id encoding (matches the turn register decode),
// turn FSM state encoding, and a helper that returns the opposing player.
package game_pkg;

  typedef enum logic [1:0] {
    PLAYER_NONE = 2'b00,
    PLAYER_1    = 2'b01,
    PLAYER_2    = 2'b10
  } player_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P1_TURN = 2'd1,
    P2_TURN = 2'd2,
    DONE    = 2'd3
  } turn_state_t;

  // Opponent of a player; anything that is not a real player maps to none.
  function automatic player_t other_player(input player_t p);
    player_t result;
    case (p)
      PLAYER_1: result = PLAYER_2;
      PLAYER_2: result = PLAYER_1;
      default:  result = PLAYER_NONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Bundle of game-control inputs and turn-register outputs around the sequencer.
// master = stimulus/board side, slave = the sequencer itself.
interface turn_sequencer_if #(
  parameter int TIMER_W = 32
);
  logic               start;
  logic               game_over;
  logic               req1;
  logic               req2;
  logic               ack1;
  logic               ack2;
  logic               reg_write;
  logic [1:0]         reg_wr_data;
  logic [1:0]         active_player;
  logic [TIMER_W-1:0] time_left;
  logic               timeout;
  logic               violation;

  modport master (
    output start, game_over, req1, req2,
    input  ack1, ack2, reg_write, reg_wr_data, active_player,
           time_left, timeout, violation
  );

  modport slave (
    input  start, game_over, req1, req2,
    output ack1, ack2, reg_write, reg_wr_data, active_player,
           time_left, timeout, violation
  );
endinterface

// File: rtl/turn_sequencer_timer.sv
// Per-turn down counter: load reloads the full turn budget, dec counts down
// and saturates at zero, clear forces zero (used when the game ends).
module turn_timer #(
  parameter int TIMER_W     = 32,
  parameter int TURN_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  input  logic               clear,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TURN_CYCLES - 1);

  logic [TIMER_W-1:0] count_d;
  logic [TIMER_W-1:0] count_q;

  // Next count: clear beats load beats decrement; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {TIMER_W{1'b0}};
    end else if (load) begin
      count_d = RELOAD;
    end else if (dec && (count_q != {TIMER_W{1'b0}})) begin
      count_d = count_q - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == {TIMER_W{1'b0}});

endmodule

// File: rtl/turn_sequencer.sv
// Game-turn controller owning the write port of the player-turn register.
// Alternates turns, accepts moves only from the active player, times out idle
// turns, and clears the turn on game over. All outputs are registered.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int         TURN_CYCLES  = 500_000_000,
  parameter int         TIMER_W      = 32,
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  turn_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_P1    = P1_TURN;
  localparam logic [1:0] ST_P2    = P2_TURN;
  localparam logic [1:0] ST_DONE  = DONE;
  localparam logic [1:0] ST_FIRST = (FIRST_PLAYER == 2'b10) ? ST_P2 : ST_P1;

  logic [1:0] state_d,         state_q;
  logic       ack1_d,          ack1_q;
  logic       ack2_d,          ack2_q;
  logic       reg_write_d,     reg_write_q;
  logic [1:0] reg_wr_data_d,   reg_wr_data_q;
  logic [1:0] active_player_d, active_player_q;
  logic       timeout_d,       timeout_q;
  logic       violation_d,     violation_q;
  logic       req1_prev_d,     req1_prev_q;
  logic       req2_prev_d,     req2_prev_q;

  logic               timer_load_s;
  logic               timer_dec_s;
  logic               timer_clear_s;
  logic               timer_zero_s;
  logic [TIMER_W-1:0] timer_count_s;
  logic               own_req_s;
  logic               rise1_s;
  logic               rise2_s;
  logic [1:0]         next_player_s;

  turn_timer #(
    .TIMER_W     (TIMER_W),
    .TURN_CYCLES (TURN_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_s),
    .dec   (timer_dec_s),
    .clear (timer_clear_s),
    .count (timer_count_s),
    .zero  (timer_zero_s)
  );

  // Request decode: active player's request, rising edges, and the opponent id.
  always_comb begin
    own_req_s     = 1'b0;
    next_player_s = other_player(player_t'(active_player_q));
    rise1_s       = bus.req1 & ~req1_prev_q;
    rise2_s       = bus.req2 & ~req2_prev_q;
    if (state_q == ST_P1) begin
      own_req_s = bus.req1;
    end else if (state_q == ST_P2) begin
      own_req_s = bus.req2;
    end else begin
      own_req_s = 1'b0;
    end
  end

  // Turn FSM: start, game over, move acceptance, timeout and violation detection.
  always_comb begin
    state_d         = state_q;
    ack1_d          = 1'b0;
    ack2_d          = 1'b0;
    reg_write_d     = 1'b0;
    reg_wr_data_d   = reg_wr_data_q;
    active_player_d = active_player_q;
    timeout_d       = 1'b0;
    timer_load_s    = 1'b0;
    timer_dec_s     = 1'b0;
    timer_clear_s   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d         = ST_FIRST;
          reg_write_d     = 1'b1;
          reg_wr_data_d   = FIRST_PLAYER;
          active_player_d = FIRST_PLAYER;
          timer_load_s    = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_P1, ST_P2: begin
        if (bus.game_over) begin
          state_d         = ST_DONE;
          reg_write_d     = 1'b1;
          reg_wr_data_d   = PLAYER_NONE;
          active_player_d = PLAYER_NONE;
          timer_clear_s   = 1'b1;
        end else if (own_req_s || timer_zero_s) begin
          // A request at the expiry edge wins over the timeout.
          if (own_req_s) begin
            ack1_d = (state_q == ST_P1);
            ack2_d = (state_q == ST_P2);
          end else begin
            timeout_d = 1'b1;
          end
          state_d         = (state_q == ST_P1) ? ST_P2 : ST_P1;
          reg_write_d     = 1'b1;
          reg_wr_data_d   = next_player_s;
          active_player_d = next_player_s;
          timer_load_s    = 1'b1;
        end else begin
          timer_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only a fresh request from the waiting player counts as a violation.
    violation_d = ((state_q == ST_P1) && rise2_s) || ((state_q == ST_P2) && rise1_s);

    // An accepted request is consumed, so if the requester keeps holding it
    // into the opponent's turn it is seen as a new (out-of-turn) request.
    req1_prev_d = ack1_d ? 1'b0 : bus.req1;
    req2_prev_d = ack2_d ? 1'b0 : bus.req2;
  end

  // State, edge-detect history and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ack1_q          <= 1'b0;
      ack2_q          <= 1'b0;
      reg_write_q     <= 1'b0;
      reg_wr_data_q   <= 2'b00;
      active_player_q <= 2'b00;
      timeout_q       <= 1'b0;
      violation_q     <= 1'b0;
      req1_prev_q     <= 1'b0;
      req2_prev_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      ack1_q          <= ack1_d;
      ack2_q          <= ack2_d;
      reg_write_q     <= reg_write_d;
      reg_wr_data_q   <= reg_wr_data_d;
      active_player_q <= active_player_d;
      timeout_q       <= timeout_d;
      violation_q     <= violation_d;
      req1_prev_q     <= req1_prev_d;
      req2_prev_q     <= req2_prev_d;
    end
  end

  assign bus.ack1          = ack1_q;
  assign bus.ack2          = ack2_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.reg_wr_data   = reg_wr_data_q;
  assign bus.active_player = active_player_q;
  assign bus.time_left     = timer_count_s;
  assign bus.timeout       = timeout_q;
  assign bus.violation     = violation_q;

endmodule
